// File: rtl/sobel_mag_pkg.sv
// Shared types and defaults for the Sobel magnitude / bit-serial sqrt slice.
package sobel_mag_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, SQUARE = 2'd1, ITER = 2'd2, DONE = 2'd3} state_e;

  localparam int GRAD_W_DEF = 11;
  localparam int RAD_W_DEF  = 32;
  localparam int PIX_W_DEF  = 8;
  localparam int PIX_SAT    = (1 << PIX_W_DEF) - 1;

  function automatic int root_w(input int rad_w);
    return rad_w / 2;
  endfunction

  localparam int ROOT_W_DEF = root_w(RAD_W_DEF);

endpackage

// File: rtl/sqrt_seq_core.sv
// Restoring integer square root datapath: one root bit per step strobe, two radicand bits consumed.
module sqrt_seq_core
  import sobel_mag_pkg::*;
#(
  parameter int RAD_W  = RAD_W_DEF,
  parameter int ROOT_W = root_w(RAD_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [RAD_W-1:0]  load_rad,
  input  logic              step,
  output logic [ROOT_W-1:0] root
);

  // Remainder never exceeds 2*root, so ROOT_W+2 bits hold it; trial needs two more.
  localparam int REM_W = ROOT_W + 2;
  localparam int TRY_W = REM_W + 2;

  logic [RAD_W-1:0]  rad_q;
  logic [REM_W-1:0]  rem_q;
  logic [ROOT_W-1:0] root_q;
  logic [TRY_W-1:0]  rem_sh, trial;
  logic              neg;

  assign rem_sh = {rem_q, rad_q[RAD_W-1 -: 2]};
  assign trial  = rem_sh - {2'b00, root_q, 2'b01};
  assign neg    = trial[TRY_W-1];
  assign root   = root_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else if (load) begin
      rad_q  <= load_rad;
      rem_q  <= '0;
      root_q <= '0;
    end else if (step) begin
      rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
      rem_q  <= neg ? rem_sh[REM_W-1:0] : trial[REM_W-1:0];
      root_q <= {root_q[ROOT_W-2:0], ~neg};
    end
  end

endmodule

// File: rtl/sobel_mag_sqrt_ctrl.sv
// Sobel gradient magnitude controller: square, bit-serial sqrt, saturate, valid/ready on both sides.
module sobel_mag_sqrt_ctrl
  import sobel_mag_pkg::*;
#(
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int RAD_W  = RAD_W_DEF,
  parameter int ROOT_W = root_w(RAD_W),
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [GRAD_W-1:0] in_gx,
  input  logic signed [GRAD_W-1:0] in_gy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROOT_W-1:0]        out_root,
  output logic [PIX_W-1:0]         out_mag,
  output logic                     busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SQUARE = SQUARE;
  localparam logic [1:0] S_ITER   = ITER;
  localparam logic [1:0] S_DONE   = DONE;
  localparam int         CNT_W    = $clog2(ROOT_W + 1);
  localparam int         SAT      = (1 << PIX_W) - 1;

  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic signed [GRAD_W-1:0]  gx_q, gy_q;
  logic signed [2*GRAD_W-1:0] px, py;
  logic [2*GRAD_W:0]         sum;
  logic [ROOT_W-1:0]         root;
  logic                      accept, load, step;

  assign px = gx_q * gx_q;
  assign py = gy_q * gy_q;
  assign sum = {1'b0, px} + {1'b0, py};

  assign in_ready  = rst_n && ((state == S_IDLE) || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign load      = (state == S_SQUARE);
  // Counter runs ROOT_W..1 while stepping; the count-zero cycle lets the root settle before capture.
  assign step      = (state == S_ITER) && (cnt != '0);

  sqrt_seq_core #(.RAD_W(RAD_W), .ROOT_W(ROOT_W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_rad (RAD_W'(sum)),
    .step     (step),
    .root     (root)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gx_q     <= '0;
      gy_q     <= '0;
      out_root <= '0;
      out_mag  <= '0;
    end else begin
      if (accept) begin
        gx_q <= in_gx;
        gy_q <= in_gy;
      end
      case (state)
        S_IDLE:   if (accept) state <= S_SQUARE;
        S_SQUARE: begin
          cnt   <= CNT_W'(ROOT_W);
          state <= S_ITER;
        end
        S_ITER: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_root <= root;
            out_mag  <= (root > ROOT_W'(SAT)) ? PIX_W'(SAT) : root[PIX_W-1:0];
            state    <= S_DONE;
          end
        end
        default:  if (out_ready) state <= accept ? S_SQUARE : S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_mag_sqrt_ctrl.sv
// Directed table-driven bench for sobel_mag_sqrt_ctrl plus backpressure and reset corner sequences.
module tb_sobel_mag_sqrt_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [10:0] in_gx = '0;
  logic signed [10:0] in_gy = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        out_root;
  logic [7:0]         out_mag;
  logic               busy;

  int tests = 0;
  int fails = 0;

  sobel_mag_sqrt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_gx     (in_gx),
    .in_gy     (in_gy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_mag   (out_mag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gx;
    int gy;
    int root;
    int mag;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for out_valid, counting edges since the accept edge; returns 99 on timeout.
  task automatic wait_result(output int lat);
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin
        in_gx = 11'sd555;
        in_gy = -11'sd700;
      end
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic issue(input int gx, input int gy);
    @(negedge clk);
    in_gx    = 11'(gx);
    in_gy    = 11'(gy);
    in_valid = 1'b1;
    chk("in_ready_at_issue", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_consume", int'(out_valid), 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.gx, v.gy);
    wait_result(lat);
    chk($sformatf("latency(%0d,%0d)", v.gx, v.gy), lat, 18);
    chk($sformatf("root(%0d,%0d)", v.gx, v.gy), int'(out_root), v.root);
    chk($sformatf("mag(%0d,%0d)", v.gx, v.gy), int'(out_mag), v.mag);
    consume();
  endtask

  initial begin
    int lat;
    int seen;
    vecs[0] = '{14, 8, 16, 16};
    vecs[1] = '{-12, 10, 15, 15};
    vecs[2] = '{0, 0, 0, 0};
    vecs[3] = '{1020, 1020, 1442, 255};
    vecs[4] = '{-1024, -1024, 1448, 255};
    vecs[5] = '{255, 0, 255, 255};
    vecs[6] = '{256, 0, 256, 255};
    vecs[7] = '{100, 100, 141, 141};
    vecs[8] = '{1023, 1023, 1446, 255};
    vecs[9] = '{0, -254, 254, 254};

    #2;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_root", int'(out_root), 0);
    chk("rst_out_mag", int'(out_mag), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: stall in DONE, then consume and accept a new pair on the same edge.
    issue(14, 8);
    wait_result(lat);
    chk("bp_latency", lat, 18);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_held", int'(out_valid), 1);
      chk("bp_root_held", int'(out_root), 16);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    @(negedge clk);
    in_gx     = 11'sd3;
    in_gy     = 11'sd4;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_consumed", int'(out_valid), 0);
    chk("bp_busy_new", int'(busy), 1);
    wait_result(lat);
    chk("bp_new_latency", lat, 18);
    chk("bp_new_root", int'(out_root), 5);
    consume();

    // Reset during the seventh ITER cycle: nothing may come out afterwards.
    issue(100, 100);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_out_root", int'(out_root), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    run_vec('{3, 4, 5, 5});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
